// File: rtl/mips_pkg.sv
// Shared types for the MEM/WB slice of the five-stage MIPS core.
// State encoding and the bundle handed from MEM to write-back.
package mips_pkg;

    localparam int WORD_W = 32;
    localparam int REG_W  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DROP = 2'b10
    } mem_state_e;

    typedef struct packed {
        logic              RegWrite;
        logic              MemtoReg;
        logic [WORD_W-1:0] ReadData;
        logic [WORD_W-1:0] ALUResult;
        logic [REG_W-1:0]  WriteReg;
        logic              valid;
    } mem_wb_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register; an all-zero bundle is a bubble.
// Asynchronous active-low reset clears it to a bubble.
module mem_wb_reg
    import mips_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  mem_wb_t wb_d,
    output mem_wb_t wb_q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: req/ack handshake to a variable-latency data memory,
// upstream stall, timeout/misalignment squash, and the MEM/WB register.
module mem_wb_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              RegWriteIn,
    input  logic              MemtoRegIn,
    input  logic              MemWriteIn,
    input  logic [WORD_W-1:0] ALUResultIn,
    input  logic [REG_W-1:0]  WriteRegIn,
    input  logic [WORD_W-1:0] WriteDataIn,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [WORD_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    input  logic [WORD_W-1:0] mem_rdata,
    input  logic              mem_ack,
    input  logic              err_clr,
    output logic              RegWriteOut,
    output logic              MemtoRegOut,
    output logic [WORD_W-1:0] ReadDataOut,
    output logic [WORD_W-1:0] ALUResultOut,
    output logic [REG_W-1:0]  WriteRegOut,
    output logic              wb_valid,
    output logic              mem_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    mem_wb_t          wb_d, wb_q;

    logic mem_op;
    logic misal;
    logic done;
    logic timeout;

    assign mem_op = in_valid & (MemtoRegIn | MemWriteIn);
    assign misal  = mem_op & (ALUResultIn[1:0] != 2'b00);

    // Gated by rst_n so a request is withdrawn the moment reset lands.
    assign mem_req   = rst_n & mem_op & ~misal & (state_q != DROP);
    assign stall     = mem_req & ~mem_ack;
    assign done      = mem_req & mem_ack;
    assign mem_we    = MemWriteIn;
    assign mem_addr  = ALUResultIn;
    assign mem_wdata = WriteDataIn;

    assign timeout = (state_q == WAIT) & ~done & (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (stall) begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            WAIT: begin
                if (done) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = DROP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DROP: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        err_d = err_q;
        if (misal | timeout) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_comb begin
        wb_d = '0;
        if (in_valid & ~mem_op) begin
            wb_d.RegWrite  = RegWriteIn;
            wb_d.MemtoReg  = MemtoRegIn;
            wb_d.ALUResult = ALUResultIn;
            wb_d.WriteReg  = WriteRegIn;
            wb_d.valid     = 1'b1;
        end else if (done) begin
            wb_d.RegWrite  = RegWriteIn;
            wb_d.MemtoReg  = MemtoRegIn;
            wb_d.ALUResult = ALUResultIn;
            wb_d.WriteReg  = WriteRegIn;
            wb_d.valid     = 1'b1;
            if (MemtoRegIn & ~MemWriteIn) begin
                wb_d.ReadData = mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    mem_wb_reg u_reg (
        .clk  (clk),
        .rst_n(rst_n),
        .wb_d (wb_d),
        .wb_q (wb_q)
    );

    assign RegWriteOut  = wb_q.RegWrite;
    assign MemtoRegOut  = wb_q.MemtoReg;
    assign ReadDataOut  = wb_q.ReadData;
    assign ALUResultOut = wb_q.ALUResult;
    assign WriteRegOut  = wb_q.WriteReg;
    assign wb_valid     = wb_q.valid;
    assign mem_err      = err_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage: single-cycle vector table plus
// hand-written multi-cycle sequences (wait states, timeout, reset).
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, RegWriteIn, MemtoRegIn, MemWriteIn;
    logic [31:0] ALUResultIn, WriteDataIn, mem_rdata;
    logic [4:0]  WriteRegIn;
    logic        mem_ack, err_clr;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        RegWriteOut, MemtoRegOut, wb_valid, mem_err;
    logic [31:0] ReadDataOut, ALUResultOut;
    logic [4:0]  WriteRegOut;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .RegWriteIn  (RegWriteIn),
        .MemtoRegIn  (MemtoRegIn),
        .MemWriteIn  (MemWriteIn),
        .ALUResultIn (ALUResultIn),
        .WriteRegIn  (WriteRegIn),
        .WriteDataIn (WriteDataIn),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .err_clr     (err_clr),
        .RegWriteOut (RegWriteOut),
        .MemtoRegOut (MemtoRegOut),
        .ReadDataOut (ReadDataOut),
        .ALUResultOut(ALUResultOut),
        .WriteRegOut (WriteRegOut),
        .wb_valid    (wb_valid),
        .mem_err     (mem_err)
    );

    typedef struct {
        logic        v, rw, m2r, mw, ack, clr;
        logic [31:0] alu, wdata, rdata;
        logic [4:0]  wr;
        logic        e_req, e_stall, e_wbv, e_rw, e_m2r, e_err;
        logic [31:0] e_rd, e_alu;
        logic [4:0]  e_wr;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic rw, input logic m2r,
                         input logic mw, input logic [31:0] alu,
                         input logic [31:0] wdata, input logic [4:0] wr,
                         input logic ack, input logic [31:0] rdata,
                         input logic clr);
        in_valid    = v;
        RegWriteIn  = rw;
        MemtoRegIn  = m2r;
        MemWriteIn  = mw;
        ALUResultIn = alu;
        WriteDataIn = wdata;
        WriteRegIn  = wr;
        mem_ack     = ack;
        mem_rdata   = rdata;
        err_clr     = clr;
    endtask

    task automatic bubble(input logic clr);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, clr);
    endtask

    task automatic edge1;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb_zero(input string nm);
        chk({nm, ".wb_valid"}, wb_valid, 0);
        chk({nm, ".RegWrite"}, RegWriteOut, 0);
        chk({nm, ".ALUResult"}, ALUResultOut, 0);
        chk({nm, ".ReadData"}, ReadDataOut, 0);
        chk({nm, ".WriteReg"}, WriteRegOut, 0);
    endtask

    initial begin
        // v rw m2r mw ack clr | alu wdata rdata wr |
        // req stall wbv rw m2r err | rd alu wr
        vt[0]  = '{1,1,0,0,0,0, 32'h42, 0, 0, 5,
                   0,0,1,1,0,0, 0, 32'h42, 5};
        vt[1]  = '{1,1,1,0,1,0, 32'h100, 0, 32'hDEADBEEF, 3,
                   1,0,1,1,1,0, 32'hDEADBEEF, 32'h100, 3};
        vt[2]  = '{1,0,0,1,1,0, 32'h104, 32'h1234, 32'hCAFE0000, 7,
                   1,0,1,0,0,0, 0, 32'h104, 7};
        vt[3]  = '{0,1,0,0,1,0, 32'h55, 0, 32'h77, 4,
                   0,0,0,0,0,0, 0, 0, 0};
        vt[4]  = '{1,1,0,0,1,0, 32'h99, 0, 32'hFFFF, 9,
                   0,0,1,1,0,0, 0, 32'h99, 9};
        vt[5]  = '{1,1,1,0,1,0, 32'h102, 0, 32'h5, 2,
                   0,0,0,0,0,1, 0, 0, 0};
        vt[6]  = '{1,1,0,0,0,0, 32'h10, 0, 0, 1,
                   0,0,1,1,0,1, 0, 32'h10, 1};
        vt[7]  = '{0,0,0,0,0,1, 0, 0, 0, 0,
                   0,0,0,0,0,0, 0, 0, 0};
        vt[8]  = '{1,0,0,1,0,1, 32'h101, 32'hAB, 0, 0,
                   0,0,0,0,0,1, 0, 0, 0};
        vt[9]  = '{0,0,0,0,0,1, 0, 0, 0, 0,
                   0,0,0,0,0,0, 0, 0, 0};
        vt[10] = '{1,1,1,0,1,0, 32'h8, 0, 32'h1, 31,
                   1,0,1,1,1,0, 32'h1, 32'h8, 31};

        // Reset with a live load on the inputs: request must be held off.
        rst_n = 1'b0;
        drive(1, 1, 1, 0, 32'h200, 0, 6, 0, 0, 0);
        #12;
        chk("rst.mem_req", mem_req, 0);
        chk("rst.stall", stall, 0);
        chk("rst.mem_err", mem_err, 0);
        chk_wb_zero("rst");
        bubble(0);
        #1 rst_n = 1'b1;
        edge1();

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].rw, vt[i].m2r, vt[i].mw, vt[i].alu,
                  vt[i].wdata, vt[i].wr, vt[i].ack, vt[i].rdata,
                  vt[i].clr);
            @(negedge clk);
            chk($sformatf("v%0d.mem_req", i), mem_req, vt[i].e_req);
            chk($sformatf("v%0d.stall", i), stall, vt[i].e_stall);
            chk($sformatf("v%0d.mem_we", i), mem_we, vt[i].mw);
            chk($sformatf("v%0d.mem_addr", i), mem_addr, vt[i].alu);
            edge1();
            chk($sformatf("v%0d.wb_valid", i), wb_valid, vt[i].e_wbv);
            chk($sformatf("v%0d.RegWrite", i), RegWriteOut, vt[i].e_rw);
            chk($sformatf("v%0d.MemtoReg", i), MemtoRegOut, vt[i].e_m2r);
            chk($sformatf("v%0d.ReadData", i), ReadDataOut, vt[i].e_rd);
            chk($sformatf("v%0d.ALUResult", i), ALUResultOut, vt[i].e_alu);
            chk($sformatf("v%0d.WriteReg", i), WriteRegOut, vt[i].e_wr);
            chk($sformatf("v%0d.mem_err", i), mem_err, vt[i].e_err);
        end

        // Store acked after three wait cycles.
        drive(1, 0, 0, 1, 32'h104, 32'h1234, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) begin
            mem_ack = (k == 3);
            @(negedge clk);
            chk($sformatf("st%0d.stall", k), stall, (k < 3));
            chk($sformatf("st%0d.mem_req", k), mem_req, 1);
            chk($sformatf("st%0d.mem_we", k), mem_we, 1);
            chk($sformatf("st%0d.addr", k), mem_addr, 32'h104);
            chk($sformatf("st%0d.wdata", k), mem_wdata, 32'h1234);
            edge1();
            chk($sformatf("st%0d.wb_valid", k), wb_valid, (k == 3));
            if (k == 3) begin
                chk("st.RegWrite", RegWriteOut, 0);
                chk("st.ALUResult", ALUResultOut, 32'h104);
                chk("st.ReadData", ReadDataOut, 0);
            end
        end
        bubble(0);
        edge1();
        chk("st.no_repeat", wb_valid, 0);

        // Load that never gets acked: 16 stall cycles then DROP.
        drive(1, 1, 1, 0, 32'h200, 0, 6, 0, 32'h9999, 0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("to%0d.stall", k), stall, 1);
            edge1();
            chk($sformatf("to%0d.wb_valid", k), wb_valid, 0);
            chk($sformatf("to%0d.mem_err", k), mem_err, (k == 15));
        end
        @(negedge clk);
        chk("drop.stall", stall, 0);
        chk("drop.mem_req", mem_req, 0);
        chk("drop.mem_err", mem_err, 1);
        edge1();
        chk("drop.wb_valid", wb_valid, 0);
        bubble(1);
        edge1();
        chk("clr.mem_err", mem_err, 0);
        bubble(0);
        edge1();
        chk("clr.hold", mem_err, 0);

        // Reset landing in the middle of a wait.
        drive(1, 1, 1, 0, 32'h302, 0, 6, 0, 0, 0);
        edge1();
        chk("pre.mem_err", mem_err, 1);
        drive(1, 1, 1, 0, 32'h300, 0, 6, 0, 0, 0);
        edge1();
        @(negedge clk);
        chk("rw.stall_before", stall, 1);
        rst_n = 1'b0;
        #1;
        chk("rw.mem_req", mem_req, 0);
        chk("rw.stall", stall, 0);
        chk("rw.mem_err", mem_err, 0);
        chk_wb_zero("rw");
        edge1();
        drive(1, 1, 0, 0, 32'h77, 0, 12, 0, 0, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("post.stall", stall, 0);
        edge1();
        chk("post.wb_valid", wb_valid, 1);
        chk("post.ALUResult", ALUResultOut, 32'h77);
        chk("post.WriteReg", WriteRegOut, 12);
        chk("post.RegWrite", RegWriteOut, 1);
        drive(1, 1, 1, 0, 32'h40, 0, 8, 1, 32'hA5A5A5A5, 0);
        @(negedge clk);
        chk("post.load_stall", stall, 0);
        edge1();
        chk("post.load_data", ReadDataOut, 32'hA5A5A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
MEM stage plus MEM/WB pipeline register of the five-stage MIPS core. It consumes the EX/MEM register outputs, runs a req/ack handshake with a variable-latency data memory, and produces the write-back bundle. It holds the upstream pipeline while an access is outstanding, and it squashes an access that times out or is misaligned.

Parameters:
TIMEOUT, 16, cycles without mem_ack before the access is abandoned (must be >= 2)
CNT_W, 5, width of the wait counter (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  EX/MEM holds a real instruction (0 = bubble)
RegWriteIn  in  1  instruction writes the register file
MemtoRegIn  in  1  load: WB takes memory data
MemWriteIn  in  1  store
ALUResultIn  in  32  effective address, or ALU result
WriteRegIn  in  5  destination register
WriteDataIn  in  32  store data
stall  out  1  drives EX/MEM le low and freezes earlier stages
mem_req  out  1  data-memory request
mem_we  out  1  1 = store, 0 = load
mem_addr  out  32  word address, equal to ALUResultIn
mem_wdata  out  32  equal to WriteDataIn
mem_rdata  in  32  load data, valid when mem_ack = 1
mem_ack  in  1  access completes this cycle
err_clr  in  1  clears mem_err
RegWriteOut  out  1  MEM/WB register
MemtoRegOut  out  1  MEM/WB register
ReadDataOut  out  32  MEM/WB register
ALUResultOut  out  32  MEM/WB register
WriteRegOut  out  5  MEM/WB register
wb_valid  out  1  MEM/WB holds a real instruction
mem_err  out  1  sticky fault flag (timeout or misalignment)

Behaviour:
- Definitions: mem_op = in_valid & (MemtoRegIn | MemWriteIn); misal = mem_op & (ALUResultIn[1:0] != 0).
- Reset, asynchronous:
  - All MEM/WB outputs, wb_valid and mem_err go to 0.
  - State goes to IDLE; counter goes to 0.
  - mem_req and stall are forced to 0 while rst_n = 0, including when reset lands mid-access.
- States: IDLE, WAIT, DROP.
- Request and stall:
  - mem_req = mem_op & ~misal & (state != DROP). It is combinational, so a zero-wait memory completes in the same cycle.
  - mem_we = MemWriteIn.
  - stall = mem_req & ~mem_ack.
- Transitions:
  - IDLE, mem_req & ~mem_ack: go to WAIT, counter = 1.
  - WAIT, mem_ack: go to IDLE, counter = 0.
  - WAIT, ~mem_ack, counter == TIMEOUT-1: go to DROP, set mem_err.
  - WAIT otherwise: counter increments.
  - DROP: go to IDLE unconditionally. stall = 0 in DROP, so the upstream stage advances past the failed instruction.
- MEM/WB update, every rising edge:
  - Non-memory valid instruction: pass-through with 1-cycle latency. wb_valid = 1, ReadDataOut = 0.
  - mem_req & mem_ack: capture the instruction. ReadDataOut = mem_rdata for loads, 0 for stores. wb_valid = 1.
  - All other cases insert a bubble: wb_valid = 0, RegWriteOut = 0, other fields = 0. This covers waiting, DROP, misal, and in_valid = 0.
  - No instruction reaches WB twice.
- Misalignment: no request is issued and stall stays 0. mem_err is set and the instruction becomes a bubble.
- mem_err: sticky. err_clr clears it, but a new error in the same cycle wins.
- mem_ack sampled while mem_req = 0 is ignored.
- While stalled, the inputs are assumed stable. mem_addr, mem_wdata and mem_we must stay stable while mem_req = 1.

Decomposition:
- Shared package mips_pkg:
  - state encoding: IDLE = 2'b00, WAIT = 2'b01, DROP = 2'b10
  - MEM/WB bundle struct: RegWrite, MemtoReg, ReadData, ALUResult, WriteReg, valid
  - WORD_W = 32, REG_W = 5
- One sub-module is natural: mem_wb_reg, the bubble-capable MEM/WB register with async active-low reset.
- The FSM, counter and handshake logic stay in the top level.

Test Plan:
- ALU op in_valid = 1, RegWriteIn = 1, ALUResultIn = 0x0000_0042, WriteRegIn = 5 -> next edge: wb_valid = 1, ALUResultOut = 0x42, WriteRegOut = 5, stall never 1.
- Load at addr 0x100, mem_ack = 1 same cycle, mem_rdata = 0xDEADBEEF -> no stall; next edge: ReadDataOut = 0xDEADBEEF, MemtoRegOut = 1.
- Store at addr 0x104, WriteDataIn = 0x1234, ack after 3 cycles -> stall = 1 for 3 cycles with mem_we = 1 and stable addr/data; bubbles in WB meanwhile; exactly one wb_valid pulse with RegWriteOut = 0.
- Load with no ack, TIMEOUT = 16 -> stall high for 16 cycles, then DROP cycle with stall = 0 and mem_err = 1, WB bubble; err_clr pulse -> mem_err = 0.
- Load at addr 0x102 -> mem_req = 0, stall = 0, mem_err = 1, wb_valid = 0 next edge.
- rst_n low during WAIT (cycle 2 of 5) -> mem_req/stall drop immediately, all outputs 0; after release, the next ALU op passes with 1-cycle latency.
